// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and
// single-cycle rx_ready / frame_err pulses for the byte handlers downstream.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_active,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_ONE       = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bidx;
    logic [7:0]      r_sh;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_ferr;
    logic            r_active;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;

    // Synchroniser resets to the idle level so release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bidx   <= '0;
            r_sh     <= '0;
            r_data   <= '0;
            r_ready  <= 1'b0;
            r_ferr   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_active <= 1'b0;
                    if (!w_rx_s) begin
                        r_state  <= S_START;
                        r_cnt    <= '0;
                        r_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_bidx  <= '0;
                        end else begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt <= '0;
                        r_sh  <= {w_rx_s, r_sh[7:1]};
                        if (r_bidx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bidx <= r_bidx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_STOP: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                        if (w_rx_s) begin
                            r_data  <= r_sh;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_BREAK: begin
                    r_active <= 1'b0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready  = r_ready;
    assign rx_data   = r_data;
    assign rx_active = r_active;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random frames/glitches/bad stops,
// compared against a queue-based model of what the line should deliver.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_active;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_active (rx_active),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Written only by the monitor.
    logic [7:0] got_q[$];
    int         ferr_seen    = 0;
    int         active_rises = 0;
    int         excl_cnt     = 0;
    int         act_bad_cnt  = 0;
    logic       prev_active  = 1'b0;

    // Model state, written only by the stimulus process.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    int         cmp_idx  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_ready && frame_err) excl_cnt++;
            if (rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_seen++;
            if ((rx_ready || frame_err) && (rx_active || !prev_active)) act_bad_cnt++;
            if (rx_active && !prev_active) active_rises++;
        end
        prev_active = rx_active;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = cmp_idx; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        cmp_idx = exp_q.size();
        check_eq({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
        check_eq({tag, "_excl"}, 32'(excl_cnt), 32'd0);
        check_eq({tag, "_actfall"}, 32'(act_bad_cnt), 32'd0);
        check_eq({tag, "_data"}, 32'(rx_data), 32'(exp_data));
        $display("[%0t] %s: bytes=%0d frame_errs=%0d rx_data=%02h", $time, tag,
                 got_q.size(), ferr_seen, rx_data);
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        int         gap;
        int         r0;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_ready",  32'(rx_ready),  32'd0);
        check_eq("rst_ferr",   32'(frame_err), 32'd0);
        check_eq("rst_active", 32'(rx_active), 32'd0);
        check_eq("rst_data",   32'(rx_data),   32'd0);
        reset = 1'b0;
        idle(10);

        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        exp_data = 8'h55;
        idle(20);
        verify("b55");

        r0 = active_rises;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check_eq("glitch_active_pulse", 32'(active_rises - r0), 32'd1);
        check_eq("glitch_active_end", 32'(rx_active), 32'd0);
        verify("glitch");

        send_frame(8'hA3, 1'b0);
        repeat (CPB) @(negedge clk);
        exp_ferr++;
        idle(20);
        verify("break");
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        exp_data = 8'h3C;
        idle(20);
        verify("after_break");

        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_data = 8'hFF;
        idle(20);
        verify("b2b");

        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_data", 32'(rx_data), 32'd0);
        check_eq("midrst_active", 32'(rx_active), 32'd0);
        reset = 1'b0;
        exp_data = 8'h00;
        idle(20);
        verify("midrst");
        send_frame(8'h7E, 1'b1);
        exp_q.push_back(8'h7E);
        exp_data = 8'h7E;
        idle(20);
        verify("after_rst");

        for (int k = 0; k < 40; k++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(0, 20);
            if (kind == 1) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                idle(10);
            end
            if (kind == 0) begin
                send_frame(b, 1'b0);
                repeat (CPB) @(negedge clk);
                idle(6);
                exp_ferr++;
            end else begin
                send_frame(b, 1'b1);
                exp_q.push_back(b);
                exp_data = b;
            end
            $display("[%0t] frame %0d: byte=%02h kind=%0d gap=%0d", $time, k, b, kind, gap);
            idle(gap);
        end
        idle(20);
        verify("rand");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
